// File: rtl/dbus_pkg.sv
// Shared types and helpers for the data-side bus controller.
//   size_e     : access size encoding as seen on req_size / SIZE
//   state_e    : controller FSM states
//   is_aligned : true when an access of the given size may start at addr[1:0]
package dbus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Size code 2'b11 has no enum member and is handled as a word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        if (size == SZ_BYTE) begin
            ok = 1'b1;
        end else if (size == SZ_HALF) begin
            ok = ~addr_lo[0];
        end else begin
            ok = (addr_lo == 2'b00);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Combinational lane steering for the data bus.
//   wr_size, wr_data           : store size and right-aligned store data
//   wr_lanes                   : store data replicated across all lanes
//   rd_size, rd_addr_lo        : load size and byte offset within the word
//   rd_unsigned                : 1 = zero-extend, 0 = sign-extend
//   rd_bus                     : raw 32-bit word from the bus
//   rd_data                    : selected lane, extended to 32 bits
module dbus_lane_align
    import dbus_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    output logic [31:0] wr_lanes,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic        rd_unsigned,
    input  logic [31:0] rd_bus,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Stores: the slave picks its lane from DAD/SIZE, so every lane carries the data.
    always_comb begin
        wr_lanes = wr_data;
        if (wr_size == SZ_BYTE) begin
            wr_lanes = {4{wr_data[7:0]}};
        end else if (wr_size == SZ_HALF) begin
            wr_lanes = {2{wr_data[15:0]}};
        end
    end

    // Loads: little-endian lane select, byte lane = addr[1:0], half lane = addr[1].
    always_comb begin
        case (rd_addr_lo)
            2'b00:   byte_sel = rd_bus[7:0];
            2'b01:   byte_sel = rd_bus[15:8];
            2'b10:   byte_sel = rd_bus[23:16];
            default: byte_sel = rd_bus[31:24];
        endcase
        half_sel = rd_addr_lo[1] ? rd_bus[31:16] : rd_bus[15:0];

        rd_data = rd_bus;
        if (rd_size == SZ_BYTE) begin
            rd_data = {{24{~rd_unsigned & byte_sel[7]}}, byte_sel};
        end else if (rd_size == SZ_HALF) begin
            rd_data = {{16{~rd_unsigned & half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: turns one memory-stage load/store into a single
// MREQ/ACKD_n handshaked bus cycle.
//   Handshake: accepted in IDLE when req_valid & aligned; MREQ rises on the next
//   edge and stays high until ACKD_n is sampled low (or the timeout expires);
//   one DONE cycle follows before the next request is considered.
//   clk, rst                          : clock, async active-low reset
//   req_*                             : request from memory stage (held while stall=1)
//   stall                             : combinational pipeline freeze
//   rdata_valid, rdata                : load result pulse
//   misalign_err, bus_err             : one-cycle error pulses
//   DAD, DDT_out, DDT_oe, DDT_in      : bus address / data
//   MREQ, WRITE, SIZE, ACKD_n         : bus control
module data_bus_ctrl
    import dbus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        misalign_err,
    output logic        bus_err,
    output logic [31:0] DAD,
    output logic [31:0] DDT_out,
    output logic        DDT_oe,
    input  logic [31:0] DDT_in,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    // timer counts completed MREQ cycles; the last allowed one is TIMEOUT_CYC-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state;
    logic [7:0]  timer;
    logic [1:0]  addr_lo;
    logic        load_unsigned;
    logic        aligned;
    logic [31:0] wr_lanes;
    logic [31:0] rd_ext;

    assign aligned = is_aligned(req_size, req_addr[1:0]);
    assign stall   = ((state == IDLE) && req_valid && aligned) || (state == REQ);

    dbus_lane_align u_lane (
        .wr_size     (req_size),
        .wr_data     (req_wdata),
        .wr_lanes    (wr_lanes),
        .rd_size     (SIZE),
        .rd_addr_lo  (addr_lo),
        .rd_unsigned (load_unsigned),
        .rd_bus      (DDT_in),
        .rd_data     (rd_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            timer         <= 8'd0;
            addr_lo       <= 2'b00;
            load_unsigned <= 1'b0;
            MREQ          <= 1'b0;
            WRITE         <= 1'b0;
            DDT_oe        <= 1'b0;
            DAD           <= 32'd0;
            DDT_out       <= 32'd0;
            SIZE          <= 2'b00;
            rdata         <= 32'd0;
            rdata_valid   <= 1'b0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            rdata_valid  <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (aligned) begin
                            state         <= REQ;
                            timer         <= 8'd0;
                            MREQ          <= 1'b1;
                            WRITE         <= req_write;
                            DDT_oe        <= req_write;
                            DAD           <= {req_addr[31:2], 2'b00};
                            SIZE          <= req_size;
                            DDT_out       <= wr_lanes;
                            addr_lo       <= req_addr[1:0];
                            load_unsigned <= req_unsigned;
                        end else begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!ACKD_n) begin
                        MREQ   <= 1'b0;
                        WRITE  <= 1'b0;
                        DDT_oe <= 1'b0;
                        state  <= DONE;
                        // WRITE still holds this access's direction here.
                        if (!WRITE) begin
                            rdata       <= rd_ext;
                            rdata_valid <= 1'b1;
                        end
                    end else if (timer == TMO_LAST) begin
                        MREQ    <= 1'b0;
                        WRITE   <= 1'b0;
                        DDT_oe  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
